// File: rtl/mac_rx_frame_check.sv
// Ethernet MAC receive stage: preamble/SFD strip, header capture, destination filter,
// FCS strip and frame status. Define MAC_RX_CRC_CHK_EN to enable the CRC-32 check.
module mac_rx_frame_check #(
  parameter int P_MAX_PRE = 7,
  parameter int P_MAX_LEN = 1500
) (
  input  logic        i_udp_stack_clk,
  input  logic        i_udp_stack_rst_n,
  input  logic [7:0]  i_gmii_data,
  input  logic        i_gmii_valid,
  input  logic [47:0] i_local_mac,
  input  logic        i_promisc,
  output logic [7:0]  o_mac_data,
  output logic        o_mac_valid,
  output logic        o_mac_last,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_eth_type,
  output logic        o_frame_end,
  output logic        o_frame_ok,
  output logic        o_crc_err,
  output logic        o_len_err,
  output logic [10:0] o_frame_len,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_pre_cnt;
  logic [3:0]  r_hdr_cnt;
  logic [31:0] r_dl;
  logic [2:0]  r_dl_cnt;
  logic [7:0]  r_hb;
  logic        r_hb_vld;
  logic [10:0] r_len_cnt;

  logic [7:0]  r_mac_data;
  logic        r_mac_valid, r_mac_last;
  logic [47:0] r_dst_mac, r_src_mac;
  logic [15:0] r_eth_type;
  logic        r_frame_end, r_frame_ok, r_crc_err, r_len_err;
  logic [10:0] r_frame_len;
  logic [15:0] r_drop_cnt;

  logic        w_is_55, w_is_d5, w_addr_ok, w_sfd, w_hdr_last;
  logic        w_pay_in, w_fall_pay, w_fall_hdr, w_dl_full, w_runt, w_len_bad, w_crc_bad;
  logic [10:0] w_len_final;

  assign w_is_55    = (i_gmii_data == 8'h55);
  assign w_is_d5    = (i_gmii_data == 8'hD5);
  assign w_addr_ok  = (r_dst_mac == i_local_mac) || (&r_dst_mac) || i_promisc;
  assign w_sfd      = (r_state == S_PRE) && i_gmii_valid && w_is_d5;
  assign w_hdr_last = (r_state == S_HDR) && i_gmii_valid && (r_hdr_cnt == 4'd13);
  assign w_pay_in   = (r_state == S_PAY) && i_gmii_valid;
  assign w_fall_pay = (r_state == S_PAY) && !i_gmii_valid;
  assign w_fall_hdr = (r_state == S_HDR) && !i_gmii_valid;
  assign w_dl_full  = (r_dl_cnt == 3'd4);
  // The holdback byte still pending at the fall is the final payload byte.
  assign w_len_final = (r_hb_vld && (r_len_cnt != 11'h7FF)) ? r_len_cnt + 11'd1 : r_len_cnt;
  assign w_runt      = w_fall_hdr || (w_fall_pay && !r_hb_vld);
  assign w_len_bad   = w_runt || (w_len_final > 11'(P_MAX_LEN));

  always_ff @(posedge i_udp_stack_clk or negedge i_udp_stack_rst_n) begin
    if (!i_udp_stack_rst_n) r_state <= S_IDLE;
    else                    r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_gmii_valid) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = w_is_55 ? S_PRE : S_DROP;
        S_PRE: begin
          if (w_is_55 && (r_pre_cnt < 8'(P_MAX_PRE))) w_state_nxt = S_PRE;
          else if (w_is_d5)                            w_state_nxt = S_HDR;
          else                                         w_state_nxt = S_DROP;
        end
        S_HDR: if (r_hdr_cnt == 4'd13) w_state_nxt = w_addr_ok ? S_PAY : S_DROP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_udp_stack_clk or negedge i_udp_stack_rst_n) begin
    if (!i_udp_stack_rst_n) begin
      r_pre_cnt   <= '0;
      r_hdr_cnt   <= '0;
      r_dl        <= '0;
      r_dl_cnt    <= '0;
      r_hb        <= '0;
      r_hb_vld    <= 1'b0;
      r_len_cnt   <= '0;
      r_mac_data  <= '0;
      r_mac_valid <= 1'b0;
      r_mac_last  <= 1'b0;
      r_dst_mac   <= '0;
      r_src_mac   <= '0;
      r_eth_type  <= '0;
      r_frame_end <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_crc_err   <= 1'b0;
      r_len_err   <= 1'b0;
      r_frame_len <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_mac_valid <= 1'b0;
      r_mac_last  <= 1'b0;
      r_frame_end <= 1'b0;

      if ((r_state == S_IDLE) && i_gmii_valid)
        r_pre_cnt <= 8'd1;
      else if ((r_state == S_PRE) && i_gmii_valid && w_is_55)
        r_pre_cnt <= r_pre_cnt + 8'd1;

      if (w_sfd) begin
        r_hdr_cnt <= '0;
        r_dl_cnt  <= '0;
        r_hb_vld  <= 1'b0;
        r_len_cnt <= '0;
      end

      if ((r_state == S_HDR) && i_gmii_valid) begin
        r_hdr_cnt <= r_hdr_cnt + 4'd1;
        if (r_hdr_cnt < 4'd6)       r_dst_mac  <= {r_dst_mac[39:0], i_gmii_data};
        else if (r_hdr_cnt < 4'd12) r_src_mac  <= {r_src_mac[39:0], i_gmii_data};
        else                        r_eth_type <= {r_eth_type[7:0], i_gmii_data};
      end

      if (w_hdr_last && !w_addr_ok && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;

      // Four bytes of delay hide the FCS; the holdback lets the last payload byte carry o_mac_last.
      if (w_pay_in) begin
        r_dl <= {r_dl[23:0], i_gmii_data};
        if (!w_dl_full) begin
          r_dl_cnt <= r_dl_cnt + 3'd1;
        end else begin
          r_hb     <= r_dl[31:24];
          r_hb_vld <= 1'b1;
          if (r_hb_vld) begin
            r_mac_data  <= r_hb;
            r_mac_valid <= 1'b1;
            if (r_len_cnt != 11'h7FF) r_len_cnt <= r_len_cnt + 11'd1;
          end
        end
      end

      if (w_fall_pay || w_fall_hdr) begin
        r_frame_end <= 1'b1;
        if (w_fall_pay && r_hb_vld) begin
          r_mac_data  <= r_hb;
          r_mac_valid <= 1'b1;
          r_mac_last  <= 1'b1;
        end
        r_frame_len <= w_len_final;
        r_len_err   <= w_len_bad;
        r_crc_err   <= w_crc_bad;
        r_frame_ok  <= !w_len_bad && !w_crc_bad;
        r_hb_vld    <= 1'b0;
        r_dl_cnt    <= '0;
      end
    end
  end

`ifdef MAC_RX_CRC_CHK_EN
  logic [31:0] r_crc;

  function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c;
    for (int unsigned i = 0; i < 8; i++)
      x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  always_ff @(posedge i_udp_stack_clk or negedge i_udp_stack_rst_n) begin
    if (!i_udp_stack_rst_n)
      r_crc <= '1;
    else if (w_sfd)
      r_crc <= '1;
    else if (((r_state == S_HDR) || (r_state == S_PAY)) && i_gmii_valid)
      r_crc <= f_crc_byte(r_crc, i_gmii_data);
  end

  // Running over dst..FCS leaves the fixed CRC-32 residue when the FCS is intact.
  assign w_crc_bad = (r_crc != 32'hDEBB20E3);
`else
  assign w_crc_bad = 1'b0;
`endif

  assign o_mac_data  = r_mac_data;
  assign o_mac_valid = r_mac_valid;
  assign o_mac_last  = r_mac_last;
  assign o_dst_mac   = r_dst_mac;
  assign o_src_mac   = r_src_mac;
  assign o_eth_type  = r_eth_type;
  assign o_frame_end = r_frame_end;
  assign o_frame_ok  = r_frame_ok;
  assign o_crc_err   = r_crc_err;
  assign o_len_err   = r_len_err;
  assign o_frame_len = r_frame_len;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_mac_rx_frame_check.sv
// Scoreboard bench for mac_rx_frame_check: frame-level reference model feeds expected
// payload/status queues that a negedge monitor drains.
module tb_mac_rx_frame_check;

  localparam int P_MAX_PRE = 7;
  localparam int P_MAX_LEN = 1500;
  localparam logic [47:0] LOCAL = 48'h00_11_22_33_44_55;
  localparam logic [47:0] OTHER = 48'h00_11_22_33_44_66;
  localparam logic [47:0] SRC   = 48'h02_AA_BB_CC_DD_EE;

  typedef logic [7:0] byte_q[$];
  typedef struct { logic [7:0] d; logic last; } dat_t;
  typedef struct {
    logic [10:0] len;
    logic        len_err, crc_err, ok, runt;
    logic [47:0] dst, src;
    logic [15:0] typ;
  } stat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gd = '0;
  logic        gv = 1'b0;
  logic        prom = 1'b0;
  logic [7:0]  o_mac_data;
  logic        o_mac_valid, o_mac_last, o_frame_end, o_frame_ok, o_crc_err, o_len_err;
  logic [47:0] o_dst_mac, o_src_mac;
  logic [15:0] o_eth_type, o_drop_cnt;
  logic [10:0] o_frame_len;

  dat_t  exp_d[$];
  stat_t exp_s[$];
  dat_t  m_d;
  stat_t m_s;
  int    n_chk = 0, n_pass = 0, exp_drop = 0;
  bit    mon_en = 1'b1;

  mac_rx_frame_check #(.P_MAX_PRE(P_MAX_PRE), .P_MAX_LEN(P_MAX_LEN)) dut (
    .i_udp_stack_clk(clk), .i_udp_stack_rst_n(rst_n),
    .i_gmii_data(gd), .i_gmii_valid(gv), .i_local_mac(LOCAL), .i_promisc(prom),
    .o_mac_data(o_mac_data), .o_mac_valid(o_mac_valid), .o_mac_last(o_mac_last),
    .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_eth_type(o_eth_type),
    .o_frame_end(o_frame_end), .o_frame_ok(o_frame_ok), .o_crc_err(o_crc_err),
    .o_len_err(o_len_err), .o_frame_len(o_frame_len), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] crc32(input byte_q b, input int n);
    logic [31:0] c = '1;
    for (int i = 0; i < n; i++) begin
      c ^= {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected behaviour of one frame, from the raw bytes that follow the SFD.
  task automatic model(input int npre, input byte_q raw);
    int n = raw.size();
    int p;
    stat_t s;
    logic [47:0] dst = '0;
    logic [31:0] fcs;
    if (npre < 1 || npre > P_MAX_PRE) return;
    s = '{len: 11'd0, len_err: 1'b1, crc_err: 1'b0, ok: 1'b0, runt: 1'b1, dst: '0, src: '0, typ: '0};
    if (n < 14) begin exp_s.push_back(s); return; end
    for (int i = 0; i < 6; i++) dst = {dst[39:0], raw[i]};
    if (!(dst == LOCAL || dst == '1 || prom)) begin
      if (exp_drop < 65535) exp_drop++;
      return;
    end
    s.dst = dst;
    for (int i = 6; i < 12; i++) s.src = {s.src[39:0], raw[i]};
    s.typ = {raw[12], raw[13]};
    if (n - 14 < 5) begin exp_s.push_back(s); return; end
    p = n - 18;
    for (int i = 0; i < p; i++) exp_d.push_back('{d: raw[14+i], last: (i == p - 1)});
    fcs = {raw[n-1], raw[n-2], raw[n-3], raw[n-4]};
`ifdef MAC_RX_CRC_CHK_EN
    s.crc_err = (crc32(raw, n - 4) != fcs);
`else
    s.crc_err = 1'b0;
`endif
    s.runt    = 1'b0;
    s.len     = (p > 2047) ? 11'd2047 : 11'(p);
    s.len_err = (p > P_MAX_LEN);
    s.ok      = !s.len_err && !s.crc_err;
    exp_s.push_back(s);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] typ, input int plen,
                       input bit incr, output byte_q raw);
    logic [31:0] fcs;
    raw = {};
    for (int i = 0; i < 6; i++) raw.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) raw.push_back(SRC[47-8*i -: 8]);
    raw.push_back(typ[15:8]);
    raw.push_back(typ[7:0]);
    for (int i = 0; i < plen; i++) raw.push_back(incr ? 8'(i) : 8'($urandom));
    fcs = crc32(raw, raw.size());
    for (int i = 0; i < 4; i++) raw.push_back(fcs[8*i +: 8]);
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    gd = b;
    gv = 1'b1;
  endtask

  task automatic send(input int npre, input byte_q raw, input int gap);
    model(npre, raw);
    for (int i = 0; i < npre; i++) drive(8'h55);
    drive(8'hD5);
    foreach (raw[i]) drive(raw[i]);
    @(negedge clk);
    gv = 1'b0;
    repeat (gap) @(negedge clk);
    chk("drop_cnt", o_drop_cnt, 64'(exp_drop));
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (o_mac_valid) begin
        if (exp_d.size() == 0) chk("unexpected_data", 1, 0);
        else begin
          m_d = exp_d.pop_front();
          chk("data", o_mac_data, m_d.d);
          chk("last", o_mac_last, m_d.last);
        end
      end else if (o_mac_last) chk("last_without_valid", 1, 0);
      if (o_frame_end) begin
        if (exp_s.size() == 0) chk("unexpected_frame_end", 1, 0);
        else begin
          m_s = exp_s.pop_front();
          chk("frame_len", o_frame_len, m_s.len);
          chk("len_err", o_len_err, m_s.len_err);
          chk("frame_ok", o_frame_ok, m_s.ok);
          if (!m_s.runt) begin
            chk("crc_err", o_crc_err, m_s.crc_err);
            chk("dst_mac", o_dst_mac, m_s.dst);
            chk("src_mac", o_src_mac, m_s.src);
            chk("eth_type", o_eth_type, m_s.typ);
          end
        end
      end
    end
  end

  initial begin
    byte_q raw;
    int    n;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_mac_valid, 0);
    chk("rst_frame_end", o_frame_end, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    chk("rst_dst", o_dst_mac, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    build(LOCAL, 16'h0800, 46, 1'b1, raw);
    send(7, raw, 4);
    raw[60] ^= 8'h01;
    send(7, raw, 4);

    build(OTHER, 16'h0800, 46, 1'b1, raw);
    send(7, raw, 4);
    prom = 1'b1;
    send(7, raw, 4);
    prom = 1'b0;

    build('1, 16'h0800, 1500, 1'b0, raw);
    send(3, raw, 4);
    build('1, 16'h0800, 1501, 1'b0, raw);
    send(1, raw, 4);

    build(LOCAL, 16'h0806, 46, 1'b1, raw);
    while (raw.size() > 10) void'(raw.pop_back());
    send(7, raw, 4);
    build(LOCAL, 16'h0806, 46, 1'b1, raw);
    while (raw.size() > 17) void'(raw.pop_back());
    send(7, raw, 4);

    build(LOCAL, 16'h0800, 20, 1'b0, raw);
    send(8, raw, 4);

    for (int f = 0; f < 25; f++) begin
      logic [47:0] d;
      case ($urandom_range(0, 3))
        0: d = LOCAL;
        1: d = '1;
        2: d = OTHER;
        default: d = {16'($urandom), $urandom};
      endcase
      prom = ($urandom_range(0, 3) == 0);
      build(d, 16'($urandom), $urandom_range(0, 60), 1'b0, raw);
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, raw.size() - 1);
        raw[n] ^= 8'(1 << $urandom_range(0, 7));
      end
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(0, raw.size());
        while (raw.size() > n) void'(raw.pop_back());
      end
      send($urandom_range(1, 8), raw, $urandom_range(4, 8));
    end
    prom = 1'b0;

    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    build(LOCAL, 16'h0800, 46, 1'b1, raw);
    for (int i = 0; i < 7; i++) drive(8'h55);
    drive(8'hD5);
    for (int i = 0; i < 34; i++) drive(raw[i]);
    @(negedge clk);
    rst_n = 1'b0;
    gd = raw[34];
    #1;
    chk("midrst_valid", o_mac_valid, 0);
    chk("midrst_data", o_mac_data, 0);
    chk("midrst_drop_cnt", o_drop_cnt, 0);
    chk("midrst_dst", o_dst_mac, 0);
    chk("midrst_type", o_eth_type, 0);
    chk("midrst_ok", o_frame_ok, 0);
    drive(raw[35]);
    drive(raw[36]);
    rst_n = 1'b1;
    exp_d.delete();
    exp_s.delete();
    exp_drop = 0;
    mon_en = 1'b1;
    for (int i = 37; i < 46; i++) drive(raw[i]);
    @(negedge clk);
    gv = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_drop_cnt", o_drop_cnt, 0);
    send(7, raw, 4);

    repeat (20) @(negedge clk);
    chk("drain_data", exp_d.size(), 0);
    chk("drain_status", exp_s.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
